// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial bit sequencer: default word width and FSM state type.
package serial_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_len_sat.sv
// Word-length saturation: a requested length of 0 or anything above WIDTH becomes WIDTH.
module seq_len_sat
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic [CW:0] len,
    output logic [CW:0] len_sat
);

    localparam logic [CW:0] LenMax = (CW + 1)'(WIDTH);

    assign len_sat = ((len == '0) || (len > LenMax)) ? LenMax : len;

endmodule

// File: rtl/serial_bit_sequencer.sv
// Serial bit sequencer: IDLE/RUN/DONE FSM pacing one LSB-first word of up to WIDTH bits.
// Defining SERIAL_SEQ_ABORT_EN adds the abort input and aborted pulse output.
module serial_bit_sequencer
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW:0]   len,
    input  logic          pause,
    output logic [CW-1:0] count,
    output logic          shift_en,
    output logic          last,
    output logic          busy,
    output logic          done
`ifdef SERIAL_SEQ_ABORT_EN
    ,
    input  logic          abort,
    output logic          aborted
`endif
);

    localparam logic [CW:0]   LenMax   = (CW + 1)'(WIDTH);
    localparam logic [CW:0]   LenOne   = (CW + 1)'(1);
    localparam logic [CW-1:0] CountOne = CW'(1);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW:0]   len_q, len_d;
    logic [CW:0]   len_sat;
    logic          abort_run;

    seq_len_sat #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_len_sat (
        .len     (len),
        .len_sat (len_sat)
    );

`ifdef SERIAL_SEQ_ABORT_EN
    logic aborted_q;

    // Abort only matters in RUN and overrides both pause and the final bit.
    assign abort_run = abort && (state_q == StRun);
    assign aborted   = aborted_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_run;
        end
    end
`else
    assign abort_run = 1'b0;
`endif

    assign count    = count_q;
    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign shift_en = busy && !pause && !abort_run;
    assign last     = shift_en && ({1'b0, count_q} == (len_q - LenOne));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        case (state_q)
            StIdle, StDone: begin
                count_d = '0;
                if (start) begin
                    state_d = StRun;
                    len_d   = len_sat;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (abort_run) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (last) begin
                    state_d = StDone;
                end else if (shift_en) begin
                    count_d = count_q + CountOne;
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            len_q   <= LenMax;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

endmodule
